// File: rtl/program_loader_if.sv
// Signal bundle between the program loader, its external byte source and the
// controller it programs. The slave modport is the loader's view.
interface program_loader_if;
  logic       start;
  logic [4:0] prog_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cpu_ready;
  logic       cpu_read;
  logic       cpu_done;
  logic       programming;
  logic [7:0] bus_data;
  logic       bus_en;
  logic       pc_clear;
  logic       load_done;
  logic       err;
  logic [7:0] checksum;

  modport slave (
    input  start, prog_len, in_data, in_valid, cpu_ready, cpu_read, cpu_done,
    output in_ready, programming, bus_data, bus_en, pc_clear, load_done, err, checksum
  );

  modport master (
    output start, prog_len, in_data, in_valid, cpu_ready, cpu_read, cpu_done,
    input  in_ready, programming, bus_data, bus_en, pc_clear, load_done, err, checksum
  );
endinterface

// File: rtl/program_loader.sv
// Streams a short program from an external byte source through a 2-entry FIFO
// into the controller's RAM. Define LOADER_CHECKSUM_EN to enable the byte-sum output.
module program_loader (
  input  logic            clk,
  input  logic            resetn,
  program_loader_if.slave lb
);
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 5;
  localparam int MAX_LEN = 16;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH, RUN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   acc_cnt;
  logic [CNT_W-1:0]   wr_cnt;
  logic [DATA_W-1:0]  fifo_mem [2];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         occ;
  logic               prog_q, done_q, err_q;

  logic               idle_like, len_ok, start_ok, start_bad;
  logic               fifo_empty, fifo_full;
  logic [DATA_W-1:0]  head;
  logic               pop, push, in_ready_c;
  logic               underrun, stray, last_write, pc_clear_c, bus_en_c;

  assign idle_like  = (state == IDLE) || (state == RUN);
  assign len_ok     = (lb.prog_len != '0) && (lb.prog_len <= CNT_W'(MAX_LEN));
  assign start_ok   = idle_like && lb.start && len_ok;
  assign start_bad  = idle_like && lb.start && !len_ok;

  assign fifo_empty = (occ == 2'd0);
  assign fifo_full  = (occ == 2'd2);
  assign head       = fifo_mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO can still take a byte.
  assign pop        = (state == LOAD) && lb.cpu_done && !fifo_empty;
  assign in_ready_c = (state == LOAD) && (acc_cnt < len_q) && (!fifo_full || pop);
  assign push       = in_ready_c && lb.in_valid;

  assign underrun   = (state == LOAD) && lb.cpu_read && fifo_empty;
  assign stray      = idle_like && (lb.cpu_read || lb.cpu_done);
  assign last_write = (state == LOAD) && lb.cpu_done && ((wr_cnt + CNT_W'(1)) == len_q);
  assign pc_clear_c = (state == FINISH) && lb.cpu_ready;
  assign bus_en_c   = (state == LOAD) && lb.cpu_read;

  assign lb.in_ready    = in_ready_c;
  assign lb.bus_en      = bus_en_c;
  assign lb.bus_data    = (bus_en_c && !fifo_empty) ? head : '0;
  assign lb.pc_clear    = pc_clear_c;
  assign lb.programming = prog_q;
  assign lb.load_done   = done_q;
  assign lb.err         = err_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RUN: if (start_ok)   state_nx = LOAD;
      LOAD:      if (last_write) state_nx = FINISH;
      FINISH:    if (lb.cpu_ready) state_nx = RUN;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      prog_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      prog_q <= (state_nx == LOAD) || (state_nx == FINISH);
      if (start_ok)        done_q <= 1'b0;
      else if (pc_clear_c) done_q <= 1'b1;
      if (start_ok)                            err_q <= 1'b0;
      else if (start_bad || underrun || stray) err_q <= 1'b1;
    end
  end

  // Counters and FIFO pointers restart on every accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else if (start_ok) begin
      len_q   <= lb.prog_len;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
        wr_ptr  <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if ((state == LOAD) && lb.cpu_done) wr_cnt <= wr_cnt + CNT_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage only; validity is tracked by occ, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= lb.in_data;
  end

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [DATA_W-1:0] sum_mod256(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] pop_byte;

  // An underrun write contributes zero, matching what the bus carried.
  assign pop_byte = fifo_empty ? '0 : head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              sum_q <= '0;
    else if (start_ok)                        sum_q <= '0;
    else if ((state == LOAD) && lb.cpu_done)  sum_q <= sum_mod256(sum_q, pop_byte);
  end

  assign lb.checksum = sum_q;
`else
  assign lb.checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the load session.
module tb_program_loader;
  logic clk = 1'b0;
  logic resetn = 1'b1;

  program_loader_if bus();
  program_loader dut (.clk(clk), .resetn(resetn), .lb(bus.slave));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  localparam int P_IDLE = 0, P_LOAD = 1, P_FIN = 2, P_RUN = 3;
  int               m_phase, m_len, m_acc, m_wr, m_sum;
  byte unsigned     m_q[$];
  bit               m_prog, m_done, m_err;
  logic [7:0]       seen_bd;
  logic             seen_ir, seen_pc;
  logic [7:0]       cs_a3, cs_77, cs_88;

  task automatic model_reset();
    m_phase = P_IDLE; m_q.delete(); m_len = 0; m_acc = 0; m_wr = 0;
    m_sum = 0; m_prog = 0; m_done = 0; m_err = 0;
  endtask

  // One clock: drive, check at negedge against the model, advance the model.
  task automatic cyc(input bit st, input int len, input bit iv, input int d,
                     input bit rdy, input bit rd, input bit dn);
    bit   exp_ir, exp_be, exp_pc;
    int   exp_bd, exp_cs, b;
    bus.start = st; bus.prog_len = len[4:0]; bus.in_valid = iv; bus.in_data = d[7:0];
    bus.cpu_ready = rdy; bus.cpu_read = rd; bus.cpu_done = dn;
    @(negedge clk);
    exp_ir = (m_phase == P_LOAD) && (m_acc < m_len) &&
             ((m_q.size() < 2) || (dn && m_q.size() > 0));
    exp_be = (m_phase == P_LOAD) && rd;
    exp_bd = (exp_be && m_q.size() > 0) ? int'(m_q[0]) : 0;
    exp_pc = (m_phase == P_FIN) && rdy;
`ifdef LOADER_CHECKSUM_EN
    exp_cs = m_sum;
`else
    exp_cs = 0;
`endif
    check("in_ready",    32'(bus.in_ready),    32'(exp_ir));
    check("bus_en",      32'(bus.bus_en),      32'(exp_be));
    check("bus_data",    32'(bus.bus_data),    32'(exp_bd));
    check("pc_clear",    32'(bus.pc_clear),    32'(exp_pc));
    check("programming", 32'(bus.programming), 32'(m_prog));
    check("load_done",   32'(bus.load_done),   32'(m_done));
    check("err",         32'(bus.err),         32'(m_err));
    check("checksum",    32'(bus.checksum),    32'(exp_cs));
    seen_bd = bus.bus_data; seen_ir = bus.in_ready; seen_pc = bus.pc_clear;

    if (m_phase == P_IDLE || m_phase == P_RUN) begin
      if (rd || dn) m_err = 1;
      if (st) begin
        if (len >= 1 && len <= 16) begin
          m_phase = P_LOAD; m_q.delete(); m_acc = 0; m_wr = 0; m_len = len;
          m_done = 0; m_err = 0; m_sum = 0;
        end else m_err = 1;
      end
    end else if (m_phase == P_LOAD) begin
      if (rd && m_q.size() == 0) m_err = 1;
      if (dn) begin
        b = (m_q.size() > 0) ? int'(m_q.pop_front()) : 0;
        m_sum = (m_sum + b) % 256;
        m_wr++;
        if (m_wr == m_len) m_phase = P_FIN;
      end
      if (iv && exp_ir) begin m_q.push_back(d[7:0]); m_acc++; end
    end else if (m_phase == P_FIN) begin
      if (rdy) begin m_phase = P_RUN; m_done = 1; end
    end
    m_prog = (m_phase == P_LOAD) || (m_phase == P_FIN);
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    bus.start = 0; bus.prog_len = 0; bus.in_valid = 0; bus.in_data = 0;
    bus.cpu_ready = 0; bus.cpu_read = 0; bus.cpu_done = 0;
  endtask

  // Reset is asserted with bus activity still driven to show outputs drop at once.
  task automatic do_reset();
    bus.cpu_read = 1; bus.in_valid = 1; bus.cpu_ready = 1;
    resetn = 1'b0;
    #1;
    check("rst_in_ready",    32'(bus.in_ready),    32'd0);
    check("rst_programming", 32'(bus.programming), 32'd0);
    check("rst_bus_en",      32'(bus.bus_en),      32'd0);
    check("rst_bus_data",    32'(bus.bus_data),    32'd0);
    check("rst_pc_clear",    32'(bus.pc_clear),    32'd0);
    check("rst_load_done",   32'(bus.load_done),   32'd0);
    check("rst_err",         32'(bus.err),         32'd0);
    check("rst_checksum",    32'(bus.checksum),    32'd0);
    idle_in();
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit st, iv, rdy, rd, dn;
    int len;
`ifdef LOADER_CHECKSUM_EN
    cs_a3 = 8'hA3; cs_77 = 8'h77; cs_88 = 8'h88;
`else
    cs_a3 = 8'h00; cs_77 = 8'h00; cs_88 = 8'h00;
`endif
    idle_in();
    #1;
    do_reset();

    // Illegal lengths stay idle and flag an error.
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("len0_err", 32'(bus.err), 32'd1);
    check("len0_prog", 32'(bus.programming), 32'd0);
    cyc(1, 17, 0, 0, 0, 0, 0);
    check("len17_err", 32'(bus.err), 32'd1);
    check("len17_prog", 32'(bus.programming), 32'd0);

    // Three buffered bytes streamed to the controller.
    cyc(1, 3, 0, 0, 0, 0, 0);
    check("start_clears_err", 32'(bus.err), 32'd0);
    cyc(0, 0, 1, 8'h41, 0, 0, 0);
    cyc(0, 0, 1, 8'h12, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);    check("b0", 32'(seen_bd), 32'h41);
    cyc(0, 0, 1, 8'h50, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);    check("b1", 32'(seen_bd), 32'h12);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);    check("b2", 32'(seen_bd), 32'h50);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("fin_prog", 32'(bus.programming), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);    check("pc_pulse", 32'(seen_pc), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);    check("pc_once", 32'(seen_pc), 32'd0);
    check("l3_done", 32'(bus.load_done), 32'd1);
    check("l3_err",  32'(bus.err),       32'd0);
    check("l3_prog", 32'(bus.programming), 32'd0);
    check("l3_cs",   32'(bus.checksum),  32'(cs_a3));

    // Underrun on the first read; session still completes.
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);    check("ur_data", 32'(seen_bd), 32'h00);
    check("ur_err", 32'(bus.err), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 8'h77, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);    check("ur_b1", 32'(seen_bd), 32'h77);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("ur_done", 32'(bus.load_done), 32'd1);
    check("ur_cs", 32'(bus.checksum), 32'(cs_77));

    // FIFO fills at two; a pop frees room for a third.
    cyc(1, 5, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 8'hA0 + k, 0, 0, 0);
      check($sformatf("full_rdy%0d", k), 32'(seen_ir), (k < 2) ? 32'd1 : 32'd0);
    end
    cyc(0, 0, 1, 8'hB3, 0, 0, 1); check("pop_rdy", 32'(seen_ir), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Abandon mid-session after two writes, then a clean single-byte load.
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h5A, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);    check("r1_b0", 32'(seen_bd), 32'h5A);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("r1_done", 32'(bus.load_done), 32'd1);
    check("r1_err",  32'(bus.err),       32'd0);

    // Maximum length: sixteen writes without count wrap.
    cyc(1, 16, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 1, k + 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      if (k == 14) check("l16_still_load", 32'(bus.programming), 32'd1);
    end
    cyc(0, 0, 1, 8'hEE, 0, 0, 0); check("l16_no_more", 32'(seen_ir), 32'd0);
    check("l16_notdone", 32'(bus.load_done), 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 0);     check("l16_pc", 32'(seen_pc), 32'd1);
    check("l16_done", 32'(bus.load_done), 32'd1);
    check("l16_cs", 32'(bus.checksum), 32'(cs_88));

    // Stray controller strobes while running.
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("stray_err", 32'(bus.err), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      st  = ($urandom_range(0, 7) == 0);
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 16));
      iv  = $urandom_range(0, 1) == 1;
      rdy = ($urandom_range(0, 2) == 0);
      if (m_phase == P_LOAD) begin
        rd = ($urandom_range(0, 2) == 0);
        dn = ($urandom_range(0, 3) == 0);
      end else begin
        rd = !st && ($urandom_range(0, 15) == 0);
        dn = !st && ($urandom_range(0, 15) == 0);
      end
      cyc(st, len, iv, int'($urandom_range(0, 255)), rdy, rd, dn);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clk and resetn as below.
REQ-002 clk  input  1  system clock; all state changes on posedge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins a load session.
REQ-005 prog_len  input  5  number of bytes to load, 1..16; sampled on accepted start.
REQ-006 in_data  input  8  external program byte.
REQ-007 in_valid  input  1  in_data valid (external handshake).
REQ-008 in_ready  output  1  loader can accept in_data this cycle.
REQ-009 cpu_ready  input  1  controller fetch-stage strobe (T0).
REQ-010 cpu_read  input  1  controller requests a program byte (T3 while programming).
REQ-011 cpu_done  input  1  controller RAM write strobe (T4 while programming).
REQ-012 programming  output  1  puts the controller into load mode.
REQ-013 bus_data  output  8  byte presented to the bus; valid while cpu_read=1.
REQ-014 bus_en  output  1  loader drives the bus (equals cpu_read while in LOAD).
REQ-015 pc_clear  output  1  one-cycle pulse clearing the program counter at load end.
REQ-016 load_done  output  1  sticky; session completed.
REQ-017 err  output  1  sticky; underrun, overflow or bad prog_len.
REQ-018 checksum  output  8  running byte sum (see Configuration).

Function
REQ-019 States SHALL be IDLE, LOAD, FINISH, RUN; reset enters IDLE.
REQ-020 IDLE: start with prog_len in 1..16 -> LOAD, clear count, buffer, load_done, err; start with prog_len 0 or >16 -> stay IDLE, set err.
REQ-021 start SHALL be ignored in LOAD and FINISH; in RUN it restarts as in IDLE.
REQ-022 programming SHALL be 1 in LOAD and FINISH, 0 in IDLE and RUN, registered.
REQ-023 Buffer: 2-entry FIFO; in_ready = (state==LOAD) and (fifo not full) and (bytes accepted < prog_len).
REQ-024 Byte accepted when in_valid and in_ready on the same posedge; bytes offered with in_ready=0 SHALL be ignored.
REQ-025 While cpu_read=1 in LOAD, bus_data SHALL equal the FIFO head combinationally and bus_en=1; otherwise bus_data=0x00, bus_en=0.
REQ-026 On cpu_done in LOAD: pop FIFO head, increment 5-bit written count.
REQ-027 Underrun: cpu_read=1 with FIFO empty -> bus_data=0x00, err=1; the count still increments on the following cpu_done.
REQ-028 Accept and pop in the same cycle SHALL keep occupancy unchanged; full FIFO with pop SHALL accept a new byte that cycle.
REQ-029 When the written count reaches prog_len (on that cpu_done) -> FINISH.
REQ-030 FINISH: on next cpu_ready -> RUN, pc_clear=1 for exactly that one cycle, programming=0 the next cycle, load_done=1.
REQ-031 cpu_read or cpu_done seen in IDLE or RUN SHALL set err and not affect the FIFO.
REQ-032 Count SHALL never wrap; prog_len=16 ends at count 16.

Reset
REQ-033 resetn=0 SHALL immediately force: state IDLE, programming=0, in_ready=0, bus_en=0, bus_data=0x00, pc_clear=0, load_done=0, err=0, checksum=0x00, FIFO empty, count 0.
REQ-034 Reset mid-LOAD SHALL abandon the session; buffered bytes discarded; no pc_clear pulse.

Configuration
REQ-035 Macro LOADER_CHECKSUM_EN defined: checksum = mod-256 sum of bytes popped on cpu_done this session, cleared on accepted start; underrun bytes add 0x00.
REQ-036 Macro LOADER_CHECKSUM_EN undefined: checksum SHALL be constant 0x00 and no adder logic present.

Verification
REQ-037 prog_len=3, bytes 0x41,0x12,0x50 ahead of cpu_read -> bus_data 0x41,0x12,0x50 on successive cpu_read; FINISH, pc_clear one cycle at next cpu_ready; load_done=1, err=0, checksum=0xA3 (when enabled).
REQ-038 prog_len=2, first cpu_read with FIFO empty -> bus_data=0x00, err=1, load still completes after 2 cpu_done.
REQ-039 Offer 4 bytes with no cpu_done -> only 2 accepted (in_ready=0 after 2); pop then allows a 3rd.
REQ-040 start with prog_len=0 and with prog_len=17 -> stays IDLE, err=1, programming=0.
REQ-041 resetn low after 2 of 5 bytes written -> all outputs at reset values immediately; new start with prog_len=1 completes cleanly.
REQ-042 prog_len=16 -> count reaches 16 without wrap; exactly 16 cpu_done consumed, then RUN.
